imem_block_responder: RTL and testbench
=======================================

Name: imem_block_responder

Overview:
Responder end of the instruction-cache refill interface. It accepts a 6-bit block-address read request from the icache, fetches the four 32-bit words of that block from a word-wide instruction store over a REQ/ACK handshake, and assembles them into one 128-bit block. While the fetch is in progress it holds BUSYWAIT. It sits between the icache miss port and the word-wide instruction ROM.

Parameters:
BLOCK_ADDR_W, 6, width of the block address from the icache (64 blocks of 16 bytes = 1024 bytes).
WORD_W, 32, width of a backing-store word.
WORDS_PER_BLOCK, 4, number of words per block (fixed at 4; the block is 128 bits).
CNT_W, 16, width of the completed-refill counter.

Ports:
CLK  in  1  clock; every state change happens on the posedge.
RESET  in  1  reset, asynchronous, active-low.
READ  in  1  refill request from the icache.
ADDRESS  in  6  block address from the icache.
READDATA  out  128  assembled block; word k is in bits [32k+31:32k].
BUSYWAIT  out  1  high while a refill is pending.
WORD_REQ  out  1  request to the word store.
WORD_ADDR  out  8  word index {block, k[1:0]}.
WORD_DATA  in  32  word returned by the store.
WORD_ACK  in  1  WORD_DATA is valid this cycle.
REFILL_CNT  out  16  number of completed refills; saturates.

Behaviour:
- Clocking and reset: one clock (CLK); reset is asynchronous and active-low (RESET).
- While RESET is low, all of the following hold:
  - state = IDLE
  - READDATA = 0, BUSYWAIT = 0
  - WORD_REQ = 0, WORD_ADDR = 0
  - REFILL_CNT = 0, word counter k = 0
- States: IDLE, FETCH, DONE.
- IDLE:
  - BUSYWAIT = READ, combinationally, so the icache sees busy in the same cycle it raises READ.
  - On a posedge with READ = 1: latch ADDRESS into blk, set k = 0, go to FETCH.
- FETCH:
  - BUSYWAIT = 1, WORD_REQ = 1, WORD_ADDR = {blk, k}.
  - On a posedge with WORD_ACK = 1: write WORD_DATA into READDATA slice k and increment k.
  - If k was 3, go to DONE and drop WORD_REQ. Otherwise WORD_REQ stays high and WORD_ADDR advances to the next word.
  - WORD_ACK is ignored whenever WORD_REQ = 0.
- DONE:
  - Lasts exactly one cycle, with BUSYWAIT = 0 and READDATA holding the full block.
  - At the next posedge: go to IDLE and increment REFILL_CNT, holding it at 16'hFFFF once reached.
- Latency: with a zero-wait store (ACK high throughout), READ is accepted at edge 0, words are captured at edges 1–4, DONE occupies the cycle after edge 4, and BUSYWAIT falls after edge 4. Each wait cycle the store inserts adds one cycle.
- READDATA holds its value after DONE until the next refill overwrites it word by word.
- Boundary conditions:
  - ADDRESS changes during FETCH: ignored, because blk is latched.
  - READ drops during FETCH (abort): at the next posedge go to IDLE. WORD_REQ drops, k resets, REFILL_CNT is unchanged, and any ACK arriving later is ignored.
  - READ still high at the DONE→IDLE edge: no effect on that edge. Back in IDLE, BUSYWAIT follows READ, and the next posedge with READ = 1 starts a new refill with the current ADDRESS. The icache must drop READ when it sees BUSYWAIT = 0.
  - Address wrap: block 63 word 3 gives WORD_ADDR = 8'hFF. There is no carry into other state.
  - RESET asserted mid-refill: immediate return to reset values; the partial block is discarded.

Decomposition:
- Shared package (imem_pkg): BLOCK_ADDR_W, WORD_W, WORDS_PER_BLOCK, the IDLE/FETCH/DONE state encodings, and the word-index helper {blk, k}.
- Sub-module word_assembler: shift/slice write of a 32-bit word into the 128-bit register at index k, with synchronous clear. The FSM and counter stay in the top module.

Test Plan:
1. Zero-wait refill: ADDRESS = 6'd2, READ = 1, store returns words 32'hA0..A3 with ACK held high. Required: WORD_ADDR = 8,9,10,11 on consecutive cycles; BUSYWAIT low after edge 4; READDATA = 128'h000000A3_000000A2_000000A1_000000A0; REFILL_CNT = 1.
2. Wait states: ADDRESS = 6'd5, ACK high only every 3rd cycle. Required: WORD_ADDR = 20..23, each held until its ACK; BUSYWAIT high for exactly 12 cycles after acceptance; correct block assembled.
3. Abort: READ drops after 2 ACKs for ADDRESS = 6'd7. Required: IDLE on the next edge, WORD_REQ = 0, REFILL_CNT unchanged; a late ACK has no effect; a subsequent refill of block 7 completes correctly.
4. Reset mid-refill: RESET low between clock edges during FETCH. Required: BUSYWAIT, WORD_REQ, READDATA and REFILL_CNT all go to 0 immediately, without waiting for a clock edge.
5. Wrap and back-to-back: ADDRESS = 6'd63 then 6'd0 with READ held across DONE. Required: WORD_ADDR = 252..255 then 0..3; two completed refills; REFILL_CNT = 2.
6. Saturation: preload the counter near max via a forced value of 16'hFFFE, then run 3 refills. Required: REFILL_CNT = 16'hFFFF, with no wrap to 0.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory block responder.
// This package holds the geometry of the refill interface, the FSM state
// encodings and two small helpers used by the responder.
package imem_pkg;

    localparam int BLOCK_ADDR_W    = 6;
    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int K_W             = 2;
    localparam int WORD_ADDR_W     = BLOCK_ADDR_W + K_W;
    localparam int BLOCK_W         = WORD_W * WORDS_PER_BLOCK;
    localparam int CNT_W           = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Word index into the store: block number in the upper bits, word in the lower two.
    function automatic logic [WORD_ADDR_W-1:0] word_index(
        input logic [BLOCK_ADDR_W-1:0] blk,
        input logic [K_W-1:0]          k
    );
        return {blk, k};
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] res;
        if (cnt == {CNT_W{1'b1}}) begin
            res = cnt;
        end else begin
            res = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

endpackage

// File: rtl/imem_block_responder_word_assembler.sv
// Collects 32-bit words into the 128-bit refill block.
// Word k lands in bits [32k+31:32k]; slices not being written keep their value,
// so a new refill overwrites the previous block one word at a time.
module word_assembler
    import imem_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               clr_i,
    input  logic               we_i,
    input  logic [K_W-1:0]     idx_i,
    input  logic [WORD_W-1:0]  word_i,
    output logic [BLOCK_W-1:0] block_o
);

    logic [BLOCK_W-1:0] block_q;
    logic [BLOCK_W-1:0] block_d;

    // Next block value: clear wins, otherwise replace only the addressed slice.
    always_comb begin
        block_d = block_q;
        if (clr_i) begin
            block_d = {BLOCK_W{1'b0}};
        end else if (we_i) begin
            case (idx_i)
                2'd0:    block_d[ 31:  0] = word_i;
                2'd1:    block_d[ 63: 32] = word_i;
                2'd2:    block_d[ 95: 64] = word_i;
                2'd3:    block_d[127: 96] = word_i;
                default: block_d = block_q;
            endcase
        end else begin
            block_d = block_q;
        end
    end

    // Block register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            block_q <= {BLOCK_W{1'b0}};
        end else begin
            block_q <= block_d;
        end
    end

    assign block_o = block_q;

endmodule

// File: rtl/imem_block_responder.sv
// Responder side of the icache refill port.
// Accepts a block read, fetches its four words from the word store over a
// REQ/ACK handshake, assembles them into READDATA and counts completed refills.
// BUSYWAIT is combinational in IDLE so the icache sees busy in the same cycle
// it raises READ; everything else comes straight from registers.
module imem_block_responder
    import imem_pkg::*;
(
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    READ,
    input  logic [BLOCK_ADDR_W-1:0] ADDRESS,
    output logic [BLOCK_W-1:0]      READDATA,
    output logic                    BUSYWAIT,
    output logic                    WORD_REQ,
    output logic [WORD_ADDR_W-1:0]  WORD_ADDR,
    input  logic [WORD_W-1:0]       WORD_DATA,
    input  logic                    WORD_ACK,
    output logic [CNT_W-1:0]        REFILL_CNT
);

    state_e                  state_q;
    state_e                  state_d;
    logic [BLOCK_ADDR_W-1:0] blk_q;
    logic [BLOCK_ADDR_W-1:0] blk_d;
    logic [K_W-1:0]          k_q;
    logic [K_W-1:0]          k_d;
    logic                    word_req_q;
    logic                    word_req_d;
    logic [CNT_W-1:0]        refill_cnt_q;
    logic [CNT_W-1:0]        refill_cnt_d;
    logic                    capture_s;
    logic                    done_s;

    // Next-state logic; an abort (READ low in FETCH) takes priority over a same-cycle ACK.
    always_comb begin
        state_d    = state_q;
        blk_d      = blk_q;
        k_d        = k_q;
        word_req_d = word_req_q;
        capture_s  = 1'b0;
        done_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (READ) begin
                    state_d    = ST_FETCH;
                    blk_d      = ADDRESS;
                    k_d        = 2'd0;
                    word_req_d = 1'b1;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_FETCH: begin
                if (!READ) begin
                    state_d    = ST_IDLE;
                    k_d        = 2'd0;
                    word_req_d = 1'b0;
                end else if (WORD_ACK && word_req_q) begin
                    capture_s = 1'b1;
                    if (k_q == 2'd3) begin
                        state_d    = ST_DONE;
                        k_d        = 2'd0;
                        word_req_d = 1'b0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                word_req_d = 1'b0;
                done_s     = 1'b1;
            end
            default: begin
                state_d    = ST_IDLE;
                k_d        = 2'd0;
                word_req_d = 1'b0;
            end
        endcase
    end

    // Completed-refill counter advances when DONE hands back to IDLE, sticking at max.
    always_comb begin
        if (done_s) begin
            refill_cnt_d = sat_inc(refill_cnt_q);
        end else begin
            refill_cnt_d = refill_cnt_q;
        end
    end

    // FSM, latched block, word counter and request registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_IDLE;
            blk_q      <= {BLOCK_ADDR_W{1'b0}};
            k_q        <= 2'd0;
            word_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            blk_q      <= blk_d;
            k_q        <= k_d;
            word_req_q <= word_req_d;
        end
    end

    // Refill counter register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            refill_cnt_q <= {CNT_W{1'b0}};
        end else begin
            refill_cnt_q <= refill_cnt_d;
        end
    end

    word_assembler u_word_assembler (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .clr_i   (1'b0),
        .we_i    (capture_s),
        .idx_i   (k_q),
        .word_i  (WORD_DATA),
        .block_o (READDATA)
    );

    // Busy gated by RESET so it reads low during reset even if READ is high.
    assign BUSYWAIT   = RESET & (((state_q == ST_IDLE) & READ) | (state_q == ST_FETCH));
    assign WORD_REQ   = word_req_q;
    assign WORD_ADDR  = word_index(blk_q, k_q);
    assign REFILL_CNT = refill_cnt_q;

endmodule

// File: tb/tb_imem_block_responder.sv
// Bench for imem_block_responder: directed scenarios plus a random phase, all
// compared every cycle against a transaction-style model of the refill port.
module tb_imem_block_responder;

    logic         CLK = 1'b0;
    logic         RESET;
    logic         READ;
    logic [5:0]   ADDRESS;
    logic [127:0] READDATA;
    logic         BUSYWAIT;
    logic         WORD_REQ;
    logic [7:0]   WORD_ADDR;
    logic [31:0]  WORD_DATA;
    logic         WORD_ACK;
    logic [15:0]  REFILL_CNT;

    always #5 CLK = ~CLK;

    imem_block_responder dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .READ       (READ),
        .ADDRESS    (ADDRESS),
        .READDATA   (READDATA),
        .BUSYWAIT   (BUSYWAIT),
        .WORD_REQ   (WORD_REQ),
        .WORD_ADDR  (WORD_ADDR),
        .WORD_DATA  (WORD_DATA),
        .WORD_ACK   (WORD_ACK),
        .REFILL_CNT (REFILL_CNT)
    );

    int checks = 0;
    int errors = 0;

    // Model: a refill in progress has a block and a count of words already received.
    bit          m_active;
    bit          m_done;
    logic [5:0]  m_blk;
    int          m_k;
    logic [31:0] m_data [4];
    int          m_cnt;

    // Last values observed by the per-cycle compare, for literal checks.
    logic         last_busy;
    logic         last_req;
    logic [7:0]   last_wa;
    logic [127:0] last_rd;
    logic [15:0]  last_cnt;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_blk    = 6'd0;
        m_k      = 0;
        m_cnt    = 0;
        for (int i = 0; i < 4; i++) m_data[i] = 32'd0;
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        if (m_done) begin
            m_done = 1'b0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else if (m_active) begin
            if (!READ) begin
                m_active = 1'b0;
                m_k      = 0;
            end else if (WORD_ACK) begin
                m_data[m_k] = WORD_DATA;
                if (m_k == 3) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_k      = 0;
                end else begin
                    m_k = m_k + 1;
                end
            end
        end else if (READ) begin
            m_active = 1'b1;
            m_blk    = ADDRESS;
            m_k      = 0;
        end
    endtask

    // Compare every output against the model for the current cycle.
    task automatic check_outputs();
        logic         exp_busy;
        logic [7:0]   exp_wa;
        logic [127:0] exp_rd;
        exp_busy = m_active ? 1'b1 : (m_done ? 1'b0 : READ);
        exp_wa   = {m_blk, 2'b00} + 8'(m_k);
        exp_rd   = {m_data[3], m_data[2], m_data[1], m_data[0]};
        last_busy = BUSYWAIT;
        last_req  = WORD_REQ;
        last_wa   = WORD_ADDR;
        last_rd   = READDATA;
        last_cnt  = REFILL_CNT;
        chk("BUSYWAIT", 128'(BUSYWAIT), 128'(exp_busy));
        chk("WORD_REQ", 128'(WORD_REQ), 128'(m_active));
        if (m_active) chk("WORD_ADDR", 128'(WORD_ADDR), 128'(exp_wa));
        chk("READDATA", READDATA, exp_rd);
        chk("REFILL_CNT", 128'(REFILL_CNT), 128'(m_cnt));
    endtask

    // One cycle: drive at negedge, compare shortly after, update model at posedge.
    task automatic step(input logic rd, input logic [5:0] ad, input logic ack, input logic [31:0] wd);
        @(negedge CLK);
        READ      = rd;
        ADDRESS   = ad;
        WORD_ACK  = ack;
        WORD_DATA = wd;
        #1;
        check_outputs();
        @(posedge CLK);
        model_edge();
    endtask

    // Zero-wait refill of block a with words base+k; READ level during DONE is hold_rd.
    task automatic refill(input logic [5:0] a, input logic [31:0] base, input logic hold_rd);
        step(1'b1, a, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, a, 1'b1, base + 32'(m_k));
        step(hold_rd, a, 1'b0, 32'd0);
    endtask

    initial begin
        int busy_cnt;
        RESET     = 1'b0;
        READ      = 1'b0;
        ADDRESS   = 6'd0;
        WORD_ACK  = 1'b0;
        WORD_DATA = 32'd0;
        model_reset();

        // Reset values.
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        READ = 1'b1;
        #1;
        chk("reset BUSYWAIT", 128'(BUSYWAIT), 128'd0);
        chk("reset WORD_REQ", 128'(WORD_REQ), 128'd0);
        chk("reset WORD_ADDR", 128'(WORD_ADDR), 128'd0);
        chk("reset READDATA", READDATA, 128'd0);
        chk("reset REFILL_CNT", 128'(REFILL_CNT), 128'd0);
        READ  = 1'b0;
        RESET = 1'b1;

        // 1. Zero-wait refill of block 2.
        step(1'b1, 6'd2, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 6'd2, 1'b1, 32'hA0 + 32'(m_k));
            chk("t1 WORD_ADDR", 128'(last_wa), 128'(8 + i));
        end
        step(1'b0, 6'd2, 1'b0, 32'd0);
        chk("t1 BUSYWAIT in DONE", 128'(last_busy), 128'd0);
        chk("t1 READDATA", last_rd, 128'h000000A3_000000A2_000000A1_000000A0);
        step(1'b0, 6'd2, 1'b0, 32'd0);
        chk("t1 REFILL_CNT", 128'(last_cnt), 128'd1);

        // 2. ACK only every third cycle, block 5.
        step(1'b1, 6'd5, 1'b0, 32'd0);
        busy_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            step(~m_done, 6'd5, (c % 3) == 2, 32'hB0 + 32'(m_k));
            if (!last_busy) break;
            busy_cnt++;
            if ((c % 3) == 2) chk("t2 WORD_ADDR", 128'(last_wa), 128'(20 + c / 3));
        end
        chk("t2 busy cycles", 128'(busy_cnt), 128'd12);
        chk("t2 READDATA", last_rd, 128'h000000B3_000000B2_000000B1_000000B0);

        // 3. Abort after two ACKs on block 7, then a clean refill of block 7.
        step(1'b1, 6'd7, 1'b0, 32'd0);
        step(1'b1, 6'd7, 1'b1, 32'hC0);
        step(1'b1, 6'd7, 1'b1, 32'hC1);
        step(1'b0, 6'd7, 1'b0, 32'd0);
        step(1'b0, 6'd7, 1'b1, 32'hDEAD);
        chk("t3 WORD_REQ after abort", 128'(last_req), 128'd0);
        chk("t3 REFILL_CNT after abort", 128'(last_cnt), 128'd2);
        step(1'b0, 6'd7, 1'b1, 32'hBEEF);
        chk("t3 late ACK ignored", last_rd, 128'h000000B3_000000B2_000000C1_000000C0);
        refill(6'd7, 32'hD0, 1'b0);
        chk("t3 READDATA", last_rd, 128'h000000D3_000000D2_000000D1_000000D0);

        // 4. Reset asserted between edges mid-refill.
        step(1'b1, 6'd9, 1'b0, 32'd0);
        step(1'b1, 6'd9, 1'b1, 32'hE0);
        @(negedge CLK);
        READ     = 1'b1;
        WORD_ACK = 1'b1;
        #2;
        RESET = 1'b0;
        #1;
        chk("t4 BUSYWAIT", 128'(BUSYWAIT), 128'd0);
        chk("t4 WORD_REQ", 128'(WORD_REQ), 128'd0);
        chk("t4 READDATA", READDATA, 128'd0);
        chk("t4 REFILL_CNT", 128'(REFILL_CNT), 128'd0);
        chk("t4 WORD_ADDR", 128'(WORD_ADDR), 128'd0);
        model_reset();
        @(negedge CLK);
        READ     = 1'b0;
        WORD_ACK = 1'b0;
        RESET    = 1'b1;

        // 5. Block 63 then block 0 with READ held across DONE.
        step(1'b1, 6'd63, 1'b0, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 6'd63, 1'b1, 32'hF0 + 32'(m_k));
            chk("t5 WORD_ADDR wrap", 128'(last_wa), 128'(252 + i));
        end
        step(1'b1, 6'd0, 1'b0, 32'd0);
        chk("t5 BUSYWAIT in DONE", 128'(last_busy), 128'd0);
        step(1'b1, 6'd0, 1'b0, 32'd0);
        chk("t5 BUSYWAIT follows READ", 128'(last_busy), 128'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 6'd0, 1'b1, 32'h10 + 32'(m_k));
            chk("t5 WORD_ADDR block0", 128'(last_wa), 128'(i));
        end
        step(1'b0, 6'd0, 1'b0, 32'd0);
        step(1'b0, 6'd0, 1'b0, 32'd0);
        chk("t5 REFILL_CNT", 128'(last_cnt), 128'd2);
        chk("t5 READDATA", last_rd, 128'h00000013_00000012_00000011_00000010);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            step(($urandom % 16) != 0, 6'($urandom), 1'($urandom), $urandom);
        end

        // 6. Counter saturation.
        step(1'b0, 6'd0, 1'b0, 32'd0);
        step(1'b0, 6'd0, 1'b0, 32'd0);
        @(negedge CLK);
        force dut.refill_cnt_q = 16'hFFFE;
        #1;
        release dut.refill_cnt_q;
        m_cnt = 32'hFFFE;
        for (int r = 0; r < 3; r++) refill(6'(r + 30), 32'h100 * 32'(r + 1), 1'b0);
        step(1'b0, 6'd0, 1'b0, 32'd0);
        chk("t6 REFILL_CNT saturated", 128'(last_cnt), 128'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
